// File: rtl/streams_tdm_serializer_if.sv
// Bus bundle between the stream memory / downstream lane stage and the TDM serializer.
// The serializer takes the slave view; whoever drives memory data and tready takes the master view.
interface streams_tdm_serializer_if #(
    parameter int CHANNELS   = 16,
    parameter int DATA_WIDTH = 64
);
    localparam int LANE_W = $clog2(CHANNELS);

    logic                           i_sym_rdy;
    logic                           o_rd_ren;
    logic                           i_rd_vld;
    logic [CHANNELS*DATA_WIDTH-1:0] i_rd_data;
    logic                           o_tvalid;
    logic                           i_tready;
    logic [DATA_WIDTH-1:0]          o_tdata;
    logic [LANE_W-1:0]              o_tlane;
    logic                           o_tsop;
    logic                           o_teop;
    logic                           o_err;

    modport master (
        output i_sym_rdy, i_rd_vld, i_rd_data, i_tready,
        input  o_rd_ren, o_tvalid, o_tdata, o_tlane, o_tsop, o_teop, o_err
    );

    modport slave (
        input  i_sym_rdy, i_rd_vld, i_rd_data, i_tready,
        output o_rd_ren, o_tvalid, o_tdata, o_tlane, o_tsop, o_teop, o_err
    );
endinterface

// File: rtl/streams_tdm_serializer.sv
// Credit-paced reader of the multi-channel stream memory with a fall-through skid buffer;
// each CHANNELS-wide word leaves as CHANNELS single-lane valid/ready beats with symbol markers.
module streams_tdm_serializer #(
    parameter int CHANNELS      = 16,
    parameter int DATA_WIDTH    = 64,
    parameter int WORDS_PER_SYM = 132,
    parameter int RD_LATENCY    = 2,
    parameter int BUF_DEPTH     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    streams_tdm_serializer_if.slave bus
);
    localparam int LANE_W = $clog2(CHANNELS);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRD_W  = PTR_W + 3;
    localparam int WL_W   = $clog2(WORDS_PER_SYM + 1);
    localparam int WRD_W  = (WORDS_PER_SYM > 1) ? $clog2(WORDS_PER_SYM) : 1;
    localparam int WORD_W = CHANNELS * DATA_WIDTH;

    if (BUF_DEPTH < RD_LATENCY + 2) begin : g_depth_check
        $error("BUF_DEPTH must be at least RD_LATENCY+2");
    end

    typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic              ren_q, ren_d;
    logic [2:0]        pend_q, pend_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WRD_W-1:0]  word_q, word_d;
    logic              err_q, err_d;

    logic [WORD_W-1:0] mem_q [BUF_DEPTH];
    logic [WORD_W-1:0] head;
    logic [CRD_W-1:0]  credit_used;
    logic              credit_ok, start, issue;
    logic              tvalid, beat, push, pop, full, drop, vld_ack, pend_ovf;

    // Credit covers buffered words, reads in flight and the read being presented right now.
    assign credit_used = CRD_W'(occ_q) + CRD_W'(inflight_q) + CRD_W'(ren_q);
    assign credit_ok   = credit_used < CRD_W'(BUF_DEPTH);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        if (start) begin
            words_left_d = WL_W'(WORDS_PER_SYM) - WL_W'(issue);
            state_d      = (words_left_d == '0) ? S_IDLE : S_READ;
        end else if (state_q == S_READ && issue) begin
            words_left_d = words_left_q - WL_W'(1);
            if (words_left_q == WL_W'(1)) state_d = S_IDLE;
        end
    end

    // An idle FSM starts on a fresh i_sym_rdy in the same cycle so the first read goes out next cycle.
    always_comb begin
        start = (state_q == S_IDLE) && ((pend_q != 3'd0) || bus.i_sym_rdy);
        issue = credit_ok && ((state_q == S_READ) || start);
        ren_d = issue;
    end

    assign tvalid   = (occ_q != '0);
    assign beat     = tvalid && bus.i_tready;
    assign pop      = beat && (lane_q == LANE_W'(CHANNELS - 1));
    assign full     = (occ_q == CNT_W'(BUF_DEPTH));
    assign vld_ack  = bus.i_rd_vld && (inflight_q != '0);
    assign push     = vld_ack && !full;
    assign drop     = bus.i_rd_vld && (full || (inflight_q == '0));
    assign pend_ovf = bus.i_sym_rdy && !start && (pend_q == 3'd7);

    always_comb begin
        pend_d = pend_q;
        case ({bus.i_sym_rdy, start})
            2'b10:   if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
            2'b01:   pend_d = pend_q - 3'd1;
            default: pend_d = pend_q;
        endcase
        inflight_d = inflight_q + CNT_W'(ren_q) - CNT_W'(vld_ack);
        occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);
        wptr_d     = wptr_q + PTR_W'(push);
        rptr_d     = rptr_q + PTR_W'(pop);
        lane_d     = beat ? lane_q + LANE_W'(1) : lane_q;
        word_d     = word_q;
        if (pop) word_d = (word_q == WRD_W'(WORDS_PER_SYM - 1)) ? '0 : word_q + WRD_W'(1);
        err_d      = err_q || pend_ovf || drop;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ren_q      <= 1'b0;
            pend_q     <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            ren_q      <= ren_d;
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wptr_q] <= bus.i_rd_data;
    end

    // Head word falls straight through; outputs are zeroed while the buffer is empty.
    assign head          = mem_q[rptr_q];
    assign bus.o_rd_ren  = ren_q;
    assign bus.o_tvalid  = tvalid;
    assign bus.o_tdata   = tvalid ? head[lane_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.o_tlane   = lane_q;
    assign bus.o_tsop    = tvalid && (word_q == '0) && (lane_q == '0);
    assign bus.o_teop    = tvalid && (word_q == WRD_W'(WORDS_PER_SYM - 1)) &&
                           (lane_q == LANE_W'(CHANNELS - 1));
    assign bus.o_err     = err_q;
endmodule

// File: tb/tb_streams_tdm_serializer.sv
// Directed bench for streams_tdm_serializer with a fixed-latency memory model
// (CHANNELS=4, WORDS_PER_SYM=3, RD_LATENCY=2, BUF_DEPTH=4; word w lane k carries 16*w+k).
module tb_streams_tdm_serializer;
    localparam int CH = 4;
    localparam int DW = 16;
    localparam int W  = 3;
    localparam int L  = 2;
    localparam int D  = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    streams_tdm_serializer_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();

    streams_tdm_serializer #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .WORDS_PER_SYM(W), .RD_LATENCY(L), .BUF_DEPTH(D)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: a read seen in cycle c returns valid data in cycle c+2.
    logic p0, p1;
    int   rd_cnt    = 0;
    int   ren_total = 0;
    int   spur_req  = 0;
    int   spur_done = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 = 1'b0; p1 = 1'b0; rd_cnt = 0;
            bus.i_rd_vld = 1'b0; bus.i_rd_data = '0;
        end else begin
            if (p1) begin
                bus.i_rd_vld = 1'b1;
                for (int k = 0; k < CH; k++) bus.i_rd_data[k*DW +: DW] = DW'(16 * (rd_cnt % W) + k);
                rd_cnt++;
            end else if (spur_done != spur_req) begin
                spur_done++;
                bus.i_rd_vld = 1'b1;
                for (int k = 0; k < CH; k++) bus.i_rd_data[k*DW +: DW] = DW'(16'h00AA + k);
            end else begin
                bus.i_rd_vld = 1'b0;
            end
            p1 = p0;
            p0 = bus.o_rd_ren;
            if (bus.o_rd_ren) ren_total++;
        end
    end

    int q_data[$], q_lane[$], q_sop[$], q_eop[$], q_cyc[$];

    task automatic clear_beats();
        q_data.delete(); q_lane.delete(); q_sop.delete(); q_eop.delete(); q_cyc.delete();
    endtask

    // mode 0: tready always 1, mode 1: tready 1,0,1,0...
    task automatic collect(input int ncyc, input int mode);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus.i_tready = (mode == 0) ? 1'b1 : (c % 2 == 0);
            if (bus.o_tvalid && bus.i_tready) begin
                q_data.push_back(int'(bus.o_tdata)); q_lane.push_back(int'(bus.o_tlane));
                q_sop.push_back(int'(bus.o_tsop));   q_eop.push_back(int'(bus.o_teop));
                q_cyc.push_back(c);
            end
        end
    endtask

    task automatic pulse_sym();
        @(negedge clk); bus.i_sym_rdy = 1'b1;
        @(negedge clk); bus.i_sym_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.i_sym_rdy = 1'b0; bus.i_tready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_rd_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", bus.o_rd_ren); end
        checks++; if (bus.o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", bus.o_tvalid); end
        checks++; if (bus.o_tdata !== 16'd0) begin errors++; $display("FAIL reset_tdata: got %0d expected 0", bus.o_tdata); end
        checks++; if (bus.o_tlane !== 2'd0) begin errors++; $display("FAIL reset_tlane: got %0d expected 0", bus.o_tlane); end
        checks++; if (bus.o_tsop !== 1'b0) begin errors++; $display("FAIL reset_tsop: got %b expected 0", bus.o_tsop); end
        checks++; if (bus.o_teop !== 1'b0) begin errors++; $display("FAIL reset_teop: got %b expected 0", bus.o_teop); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.o_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_symbol();
        int r0;
        clear_beats();
        r0 = ren_total;
        @(negedge clk); bus.i_tready = 1'b1; bus.i_sym_rdy = 1'b1;
        @(negedge clk); bus.i_sym_rdy = 1'b0;
        checks++; if (bus.o_rd_ren !== 1'b1) begin errors++; $display("FAIL single_ren_latency: got %b expected 1", bus.o_rd_ren); end
        collect(40, 0);
        checks++; if (q_data.size() != 12) begin errors++; $display("FAIL single_beat_count: got %0d expected 12", q_data.size()); end
        for (int i = 0; i < 12; i++) begin
            int gd, gl, gs, ge;
            gd = (i < q_data.size()) ? q_data[i] : -1;
            gl = (i < q_lane.size()) ? q_lane[i] : -1;
            gs = (i < q_sop.size())  ? q_sop[i]  : -1;
            ge = (i < q_eop.size())  ? q_eop[i]  : -1;
            checks++; if (gd != 16 * (i / 4) + i % 4) begin errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, gd, 16 * (i / 4) + i % 4); end
            checks++; if (gl != i % 4) begin errors++; $display("FAIL single_lane[%0d]: got %0d expected %0d", i, gl, i % 4); end
            checks++; if (gs != int'(i == 0)) begin errors++; $display("FAIL single_sop[%0d]: got %0d expected %0d", i, gs, int'(i == 0)); end
            checks++; if (ge != int'(i == 11)) begin errors++; $display("FAIL single_eop[%0d]: got %0d expected %0d", i, ge, int'(i == 11)); end
        end
        checks++; if (q_cyc.size() < 1 || q_cyc[0] != 2) begin errors++; $display("FAIL single_first_beat_cycle: got %0d expected 2", (q_cyc.size() > 0) ? q_cyc[0] : -1); end
        checks++; if (q_cyc.size() < 12 || q_cyc[11] != 13) begin errors++; $display("FAIL single_last_beat_cycle: got %0d expected 13", (q_cyc.size() > 11) ? q_cyc[11] : -1); end
        checks++; if (ren_total - r0 != 3) begin errors++; $display("FAIL single_ren_count: got %0d expected 3", ren_total - r0); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", bus.o_err); end
    endtask

    task automatic test_backpressure();
        int r0, maxc, cur, nb;
        logic        prev_stall;
        logic [20:0] prev_out, cur_out;
        clear_beats();
        r0 = ren_total; maxc = 0; prev_stall = 1'b0; prev_out = '0;
        pulse_sym();
        pulse_sym();
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            bus.i_tready = (c % 2 == 0);
            cur = int'(dut.occ_q) + int'(dut.inflight_q);
            if (cur > maxc) maxc = cur;
            cur_out = {bus.o_tvalid, bus.o_tdata, bus.o_tlane, bus.o_tsop, bus.o_teop};
            if (prev_stall) begin
                checks++;
                if (cur_out !== prev_out) begin errors++; $display("FAIL bp_hold_cycle%0d: got %h expected %h", c, cur_out, prev_out); end
            end
            if (bus.o_tvalid && bus.i_tready) q_data.push_back(int'(bus.o_tdata));
            prev_stall = bus.o_tvalid && !bus.i_tready;
            prev_out   = cur_out;
        end
        nb = q_data.size();
        checks++; if (nb != 24) begin errors++; $display("FAIL bp_beat_count: got %0d expected 24", nb); end
        for (int i = 0; i < 24; i++) begin
            int gd;
            gd = (i < nb) ? q_data[i] : -1;
            checks++; if (gd != 16 * ((i / 4) % 3) + i % 4) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, gd, 16 * ((i / 4) % 3) + i % 4); end
        end
        checks++; if (maxc > D) begin errors++; $display("FAIL bp_credit_max: got %0d expected at most %0d", maxc, D); end
        checks++; if (ren_total - r0 != 6) begin errors++; $display("FAIL bp_ren_count: got %0d expected 6", ren_total - r0); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL bp_err: got %b expected 0", bus.o_err); end
    endtask

    task automatic test_back_to_back();
        int r0, gap;
        clear_beats();
        r0 = ren_total;
        @(negedge clk); bus.i_tready = 1'b1;
        pulse_sym();
        pulse_sym();
        collect(80, 0);
        checks++; if (q_data.size() != 24) begin errors++; $display("FAIL b2b_beat_count: got %0d expected 24", q_data.size()); end
        checks++; if (ren_total - r0 != 6) begin errors++; $display("FAIL b2b_ren_count: got %0d expected 6", ren_total - r0); end
        if (q_data.size() >= 24) begin
            gap = q_cyc[12] - q_cyc[11];
            checks++; if (q_eop[11] != 1) begin errors++; $display("FAIL b2b_first_eop: got %0d expected 1", q_eop[11]); end
            checks++; if (q_sop[12] != 1) begin errors++; $display("FAIL b2b_second_sop: got %0d expected 1", q_sop[12]); end
            checks++; if (gap != 1) begin errors++; $display("FAIL b2b_sop_gap: got %0d expected 1", gap); end
            checks++; if (q_cyc[23] - q_cyc[0] != 23) begin errors++; $display("FAIL b2b_span: got %0d expected 23", q_cyc[23] - q_cyc[0]); end
            for (int i = 0; i < 24; i++) begin
                checks++; if (q_data[i] != 16 * ((i / 4) % 3) + i % 4) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, q_data[i], 16 * ((i / 4) % 3) + i % 4); end
            end
        end
    endtask

    task automatic test_saturation();
        int nsop, neop, nb;
        @(negedge clk); bus.i_tready = 1'b0;
        // First pulse starts a symbol at once, the fourth coincides with the second start.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL sat_err_before: got %b expected 0", bus.o_err); end
                checks++; if (dut.pend_q !== 3'd7) begin errors++; $display("FAIL sat_pend_before: got %0d expected 7", dut.pend_q); end
            end
            bus.i_sym_rdy = 1'b1;
        end
        @(negedge clk); bus.i_sym_rdy = 1'b0;
        checks++; if (dut.pend_q !== 3'd7) begin errors++; $display("FAIL sat_pend_hold: got %0d expected 7", dut.pend_q); end
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL sat_err_set: got %b expected 1", bus.o_err); end
        clear_beats();
        collect(300, 0);
        nb = q_data.size(); nsop = 0; neop = 0;
        for (int i = 0; i < nb; i++) begin nsop += q_sop[i]; neop += q_eop[i]; end
        checks++; if (nb != 108) begin errors++; $display("FAIL sat_beat_count: got %0d expected 108", nb); end
        checks++; if (nsop != 9) begin errors++; $display("FAIL sat_sop_count: got %0d expected 9", nsop); end
        checks++; if (neop != 9) begin errors++; $display("FAIL sat_eop_count: got %0d expected 9", neop); end
        for (int i = 0; i < nb && i < 108; i++) begin
            checks++; if (q_data[i] != 16 * ((i / 4) % 3) + i % 4) begin errors++; $display("FAIL sat_data[%0d]: got %0d expected %0d", i, q_data[i], 16 * ((i / 4) % 3) + i % 4); end
        end
    endtask

    task automatic test_spurious();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL spur_reset_clears_err: got %b expected 0", bus.o_err); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL spur_err_idle: got %b expected 0", bus.o_err); end
        spur_req++;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b expected 1", bus.o_err); end
        checks++; if (bus.o_tvalid !== 1'b0) begin errors++; $display("FAIL spur_tvalid: got %b expected 0", bus.o_tvalid); end
    endtask

    task automatic test_mid_reset();
        int nb;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); bus.i_tready = 1'b1; bus.i_sym_rdy = 1'b1;
        @(negedge clk); bus.i_sym_rdy = 1'b0;
        nb = 0;
        for (int c = 0; c < 40 && nb < 5; c++) begin
            @(negedge clk);
            if (bus.o_tvalid && bus.i_tready) nb++;
        end
        checks++; if (nb != 5) begin errors++; $display("FAIL mid_beats_before_reset: got %0d expected 5", nb); end
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (bus.o_rd_ren !== 1'b0) begin errors++; $display("FAIL mid_ren: got %b expected 0", bus.o_rd_ren); end
        checks++; if (bus.o_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b expected 0", bus.o_tvalid); end
        checks++; if (bus.o_tdata !== 16'd0) begin errors++; $display("FAIL mid_tdata: got %0d expected 0", bus.o_tdata); end
        checks++; if (bus.o_tlane !== 2'd0) begin errors++; $display("FAIL mid_tlane: got %0d expected 0", bus.o_tlane); end
        checks++; if (bus.o_tsop !== 1'b0) begin errors++; $display("FAIL mid_tsop: got %b expected 0", bus.o_tsop); end
        checks++; if (bus.o_teop !== 1'b0) begin errors++; $display("FAIL mid_teop: got %b expected 0", bus.o_teop); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", bus.o_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_beats();
        pulse_sym();
        collect(40, 0);
        checks++; if (q_data.size() != 12) begin errors++; $display("FAIL mid_post_count: got %0d expected 12", q_data.size()); end
        for (int i = 0; i < 12 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] != 16 * (i / 4) + i % 4) begin errors++; $display("FAIL mid_post_data[%0d]: got %0d expected %0d", i, q_data[i], 16 * (i / 4) + i % 4); end
            checks++; if (q_lane[i] != i % 4) begin errors++; $display("FAIL mid_post_lane[%0d]: got %0d expected %0d", i, q_lane[i], i % 4); end
            checks++; if (q_sop[i] != int'(i == 0)) begin errors++; $display("FAIL mid_post_sop[%0d]: got %0d expected %0d", i, q_sop[i], int'(i == 0)); end
            checks++; if (q_eop[i] != int'(i == 11)) begin errors++; $display("FAIL mid_post_eop[%0d]: got %0d expected %0d", i, q_eop[i], int'(i == 11)); end
        end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL mid_post_err: got %b expected 0", bus.o_err); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_sym_rdy = 1'b0;
        bus.i_tready  = 1'b0;
        test_reset();
        test_single_symbol();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_spurious();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
